rv_inst_encoder: RTL and testbench

- Encodes miniRV instructions into 32-bit RV32I machine words. Input is mnemonic-level commands: op, rd, rs1, rs2, imm.
- Writes each encoded word through an instruction-memory loader write port with an auto-incrementing address.
- Opcode classes are identical to the core's decoder classes: R, I, S, U.
- Expands the LI pseudo-instruction into one or two words. Used by the boot/self-test loader to fill IMEM before releasing the core.

---
 rtl/rv_inst_encoder.sv | 185 ++++++++++++++++++
 tb/tb_rv_inst_encoder.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_inst_encoder.sv
// miniRV-to-RV32I instruction encoder feeding the IMEM loader write port, with LI expansion.
// Optional RV_ENC_ILLEGAL_NOP_EN: illegal ops write a NOP (0x00000013) instead of nothing.
module rv_inst_encoder #(
   parameter int          ADDR_W      = 16,
   parameter int unsigned BASE_ADDR   = 0,
   parameter int          DEPTH_WORDS = 1024
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               start,
   input  logic                               in_valid,
   output logic                               in_ready,
   input  logic [3:0]                         in_op,
   input  logic [4:0]                         in_rd,
   input  logic [4:0]                         in_rs1,
   input  logic [4:0]                         in_rs2,
   input  logic [31:0]                        in_imm,
   output logic                               wr_en,
   output logic [ADDR_W-1:0]                  wr_addr,
   output logic [31:0]                        wr_data,
   output logic [$clog2(DEPTH_WORDS+1)-1:0]   word_count,
   output logic                               err_full,
   output logic                               err_illegal
);

   localparam int               CW        = $clog2(DEPTH_WORDS + 1);
   localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(4);

   localparam logic [6:0] OPC_REG  = 7'b0110011;
   localparam logic [6:0] OPC_IMM  = 7'b0010011;
   localparam logic [6:0] OPC_LOAD = 7'b0000011;
   localparam logic [6:0] OPC_JALR = 7'b1100111;
   localparam logic [6:0] OPC_STOR = 7'b0100011;
   localparam logic [6:0] OPC_LUI  = 7'b0110111;

   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,
      OP_ADDI = 4'd1,
      OP_LW   = 4'd2,
      OP_LBU  = 4'd3,
      OP_JALR = 4'd4,
      OP_SW   = 4'd5,
      OP_SB   = 4'd6,
      OP_LUI  = 4'd7,
      OP_LI   = 4'd8
   } op_e;

   typedef enum logic {
      S_IDLE,
      S_EMIT2
   } state_e;

   state_e            state;
   logic [ADDR_W-1:0] next_addr;
   logic [31:0]       pend_word;

   logic [31:0] word0;
   logic [31:0] word1;
   logic [1:0]  needed;
   logic        illegal;
   logic        imm_small;
   logic [19:0] li_hi;
   logic        has_room;

   function automatic logic [31:0] enc_r(input logic [4:0] rs2, input logic [4:0] rs1,
                                         input logic [4:0] rd);
      return {7'b0, rs2, rs1, 3'b000, rd, OPC_REG};
   endfunction

   function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd,
                                         input logic [6:0] opc);
      return {imm, rs1, f3, rd, opc};
   endfunction

   function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3);
      return {imm[11:5], rs2, rs1, f3, imm[4:0], OPC_STOR};
   endfunction

   function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd);
      return {imm, rd, OPC_LUI};
   endfunction

   // Adding 0x800 before the shift only carries into bit 12 when imm[11] is set,
   // which compensates for the sign-extension of the trailing ADDI.
   assign imm_small = (in_imm[31:11] == '0) || (in_imm[31:11] == '1);
   assign li_hi     = in_imm[31:12] + 20'(in_imm[11]);

   always_comb begin
      word0   = '0;
      word1   = '0;
      needed  = 2'd0;
      illegal = 1'b0;
      case (in_op)
         OP_ADD:  begin word0 = enc_r(in_rs2, in_rs1, in_rd); needed = 2'd1; end
         OP_ADDI: begin word0 = enc_i(in_imm[11:0], in_rs1, 3'b000, in_rd, OPC_IMM);  needed = 2'd1; end
         OP_LW:   begin word0 = enc_i(in_imm[11:0], in_rs1, 3'b010, in_rd, OPC_LOAD); needed = 2'd1; end
         OP_LBU:  begin word0 = enc_i(in_imm[11:0], in_rs1, 3'b100, in_rd, OPC_LOAD); needed = 2'd1; end
         OP_JALR: begin word0 = enc_i(in_imm[11:0], in_rs1, 3'b000, in_rd, OPC_JALR); needed = 2'd1; end
         OP_SW:   begin word0 = enc_s(in_imm[11:0], in_rs2, in_rs1, 3'b010); needed = 2'd1; end
         OP_SB:   begin word0 = enc_s(in_imm[11:0], in_rs2, in_rs1, 3'b000); needed = 2'd1; end
         OP_LUI:  begin word0 = enc_u(in_imm[19:0], in_rd); needed = 2'd1; end
         OP_LI: begin
            if (imm_small) begin
               word0  = enc_i(in_imm[11:0], 5'd0, 3'b000, in_rd, OPC_IMM);
               needed = 2'd1;
            end else begin
               word0  = enc_u(li_hi, in_rd);
               word1  = enc_i(in_imm[11:0], in_rd, 3'b000, in_rd, OPC_IMM);
               needed = (in_imm[11:0] != '0) ? 2'd2 : 2'd1;
            end
         end
         default: begin
            illegal = 1'b1;
`ifdef RV_ENC_ILLEGAL_NOP_EN
            word0  = 32'h0000_0013;
            needed = 2'd1;
`endif
         end
      endcase
   end

   // Whole command must fit; a two-word LI is never split across a full IMEM.
   assign has_room = (32'(word_count) + 32'(needed)) <= 32'(DEPTH_WORDS);
   assign in_ready = (state == S_IDLE) && !start;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         wr_en       <= 1'b0;
         wr_addr     <= BASE;
         next_addr   <= BASE;
         wr_data     <= '0;
         word_count  <= '0;
         err_full    <= 1'b0;
         err_illegal <= 1'b0;
         pend_word   <= '0;
      end else if (start) begin
         state       <= S_IDLE;
         wr_en       <= 1'b0;
         wr_addr     <= BASE;
         next_addr   <= BASE;
         word_count  <= '0;
         err_full    <= 1'b0;
         err_illegal <= 1'b0;
      end else begin
         wr_en <= 1'b0;
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  if (illegal)
                     err_illegal <= 1'b1;
                  if (needed != 2'd0) begin
                     if (!has_room) begin
                        err_full <= 1'b1;
                     end else begin
                        wr_en      <= 1'b1;
                        wr_data    <= word0;
                        wr_addr    <= next_addr;
                        next_addr  <= next_addr + ADDR_STEP;
                        word_count <= word_count + CW'(1);
                        if (needed == 2'd2) begin
                           pend_word <= word1;
                           state     <= S_EMIT2;
                        end
                     end
                  end
               end
            end
            S_EMIT2: begin
               wr_en      <= 1'b1;
               wr_data    <= pend_word;
               wr_addr    <= next_addr;
               next_addr  <= next_addr + ADDR_STEP;
               word_count <= word_count + CW'(1);
               state      <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rv_inst_encoder.sv
// Self-checking bench for rv_inst_encoder: encoding table plus space/illegal/start/reset sequences.
module tb_rv_inst_encoder;

   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH + 1);

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [3:0]    in_op = '0;
   logic [4:0]    in_rd = '0;
   logic [4:0]    in_rs1 = '0;
   logic [4:0]    in_rs2 = '0;
   logic [31:0]   in_imm = '0;
   logic          wr_en;
   logic [15:0]   wr_addr;
   logic [31:0]   wr_data;
   logic [CW-1:0] word_count;
   logic          err_full;
   logic          err_illegal;

   rv_inst_encoder #(
      .ADDR_W(16),
      .BASE_ADDR(0),
      .DEPTH_WORDS(DEPTH)
   ) dut (
      .clk(clk), .rst(rst), .start(start),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .word_count(word_count), .err_full(err_full), .err_illegal(err_illegal)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] addr;
      logic [31:0] data;
      logic [31:0] count;
   } wr_t;

   typedef struct {
      logic [3:0]  op;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [31:0] imm;
      int          n;
      logic [31:0] w0;
      logic [31:0] w1;
   } vec_t;

   wr_t   exp_q[$];
   vec_t  vecs[16];
   int    n_checks = 0;
   int    n_pass = 0;
   logic [15:0] exp_addr = '0;
   int    exp_count = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
   endtask

   task automatic push_exp(input logic [31:0] data);
      wr_t w;
      exp_count++;
      w.addr  = exp_addr;
      w.data  = data;
      w.count = 32'(exp_count);
      exp_q.push_back(w);
      exp_addr += 16'd4;
   endtask

   // Scoreboard: every IMEM write must match the head of the expected queue.
   always @(negedge clk) begin
      if (wr_en) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_write: got addr 0x%04h data 0x%08h, expected no write", wr_addr, wr_data);
         end else begin
            wr_t w;
            w = exp_q.pop_front();
            check("wr_addr", 32'(wr_addr), 32'(w.addr));
            check("wr_data", wr_data, w.data);
            check("word_count", 32'(word_count), w.count);
         end
      end
   end

   task automatic send(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [31:0] imm);
      bit ok;
      ok = 1'b0;
      in_valid = 1'b1; in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (in_ready) begin ok = 1'b1; break; end
      end
      if (!ok) begin
         n_checks++;
         $display("FAIL in_ready_timeout: got in_ready=0 for 20 cycles, expected 1");
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
      if (exp_q.size() != 0) begin
         n_checks++;
         $display("FAIL drain_timeout: got %0d writes outstanding, expected 0", exp_q.size());
      end
      @(posedge clk); #1;
   endtask

   task automatic do_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      exp_addr  = '0;
      exp_count = 0;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got no finish, expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      vecs[0]  = '{4'd0, 5'd1,  5'd2,  5'd3,  32'h0000_0000, 1, 32'h0031_00B3, 32'h0};
      vecs[1]  = '{4'd1, 5'd5,  5'd0,  5'd0,  32'hFFFF_FFFF, 1, 32'hFFF0_0293, 32'h0};
      vecs[2]  = '{4'd5, 5'd0,  5'd2,  5'd6,  32'h0000_0008, 1, 32'h0061_2423, 32'h0};
      vecs[3]  = '{4'd8, 5'd10, 5'd0,  5'd0,  32'h1234_5FFF, 2, 32'h1234_6537, 32'hFFF5_0513};
      vecs[4]  = '{4'd8, 5'd1,  5'd0,  5'd0,  32'h0000_1000, 1, 32'h0000_10B7, 32'h0};
      vecs[5]  = '{4'd8, 5'd1,  5'd0,  5'd0,  32'd100,       1, 32'h0640_0093, 32'h0};
      vecs[6]  = '{4'd2, 5'd3,  5'd4,  5'd0,  32'h0000_0010, 1, 32'h0102_2183, 32'h0};
      vecs[7]  = '{4'd3, 5'd7,  5'd8,  5'd0,  32'h0000_07FF, 1, 32'h7FF4_4383, 32'h0};
      vecs[8]  = '{4'd4, 5'd1,  5'd5,  5'd0,  32'h0000_0000, 1, 32'h0002_80E7, 32'h0};
      vecs[9]  = '{4'd6, 5'd0,  5'd10, 5'd9,  32'hFFFF_FFFF, 1, 32'hFE95_0FA3, 32'h0};
      vecs[10] = '{4'd7, 5'd2,  5'd0,  5'd0,  32'h000A_BCDE, 1, 32'hABCD_E137, 32'h0};
      vecs[11] = '{4'd8, 5'd3,  5'd0,  5'd0,  32'hFFFF_F800, 1, 32'h8000_0193, 32'h0};
      vecs[12] = '{4'd8, 5'd4,  5'd0,  5'd0,  32'h0000_0800, 2, 32'h0000_1237, 32'h8002_0213};
      vecs[13] = '{4'd8, 5'd5,  5'd0,  5'd0,  32'hFFFF_F7FF, 2, 32'hFFFF_F2B7, 32'h7FF2_8293};
      vecs[14] = '{4'd0, 5'd0,  5'd0,  5'd0,  32'h0000_0000, 1, 32'h0000_0033, 32'h0};
      vecs[15] = '{4'd1, 5'd1,  5'd1,  5'd0,  32'hFFFF_F123, 1, 32'h1230_8093, 32'h0};

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_wr_en", 32'(wr_en), 32'd0);
      check("rst_wr_addr", 32'(wr_addr), 32'd0);
      check("rst_wr_data", wr_data, 32'd0);
      check("rst_word_count", 32'(word_count), 32'd0);
      check("rst_err_full", 32'(err_full), 32'd0);
      check("rst_err_illegal", 32'(err_illegal), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;

      for (int i = 0; i < 16; i++) begin
         if (exp_count + vecs[i].n > DEPTH) begin
            drain();
            do_start();
         end
         push_exp(vecs[i].w0);
         if (vecs[i].n == 2) push_exp(vecs[i].w1);
         send(vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm);
      end
      drain();

      // LI blocks input while its second word is emitted.
      do_start();
      push_exp(32'h1234_6537);
      push_exp(32'hFFF5_0513);
      send(4'd8, 5'd10, 5'd0, 5'd0, 32'h1234_5FFF);
      @(negedge clk);
      check("emit2_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
      check("after_emit2_in_ready", 32'(in_ready), 32'd1);
      drain();

      // Full IMEM: a two-word LI is dropped whole, a single word still fits.
      do_start();
      for (int i = 0; i < 3; i++) begin
         push_exp(32'h0031_00B3);
         send(4'd0, 5'd1, 5'd2, 5'd3, 32'h0);
      end
      drain();
      send(4'd8, 5'd10, 5'd0, 5'd0, 32'h1234_5FFF);
      repeat (2) @(negedge clk);
      check("full_err_full", 32'(err_full), 32'd1);
      check("full_word_count", 32'(word_count), 32'd3);
      push_exp(32'h0031_00B3);
      send(4'd0, 5'd1, 5'd2, 5'd3, 32'h0);
      drain();
      send(4'd0, 5'd1, 5'd2, 5'd3, 32'h0);
      repeat (2) @(negedge clk);
      check("full_sticky_count", 32'(word_count), 32'd4);
      check("full_sticky_err", 32'(err_full), 32'd1);

      // Illegal op, then start while the second LI word is pending.
      do_start();
      @(negedge clk);
      check("start_clears_full", 32'(err_full), 32'd0);
      @(posedge clk); #1;
`ifdef RV_ENC_ILLEGAL_NOP_EN
      push_exp(32'h0000_0013);
`endif
      send(4'd12, 5'd1, 5'd2, 5'd3, 32'h0);
      @(negedge clk);
      check("illegal_err", 32'(err_illegal), 32'd1);
      drain();
      push_exp(32'h1234_6537);
      send(4'd8, 5'd10, 5'd0, 5'd0, 32'h1234_5FFF);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      exp_addr = '0; exp_count = 0;
      @(negedge clk);
      check("start_err_illegal", 32'(err_illegal), 32'd0);
      check("start_wr_addr", 32'(wr_addr), 32'd0);
      check("start_word_count", 32'(word_count), 32'd0);
      check("start_wr_en", 32'(wr_en), 32'd0);
      drain();

      // Reset mid-LI aborts the second word.
      push_exp(32'h1234_6537);
      send(4'd8, 5'd10, 5'd0, 5'd0, 32'h1234_5FFF);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      exp_addr = '0; exp_count = 0;
      @(negedge clk);
      check("rstli_wr_en", 32'(wr_en), 32'd0);
      check("rstli_wr_addr", 32'(wr_addr), 32'd0);
      check("rstli_word_count", 32'(word_count), 32'd0);
      drain();
      repeat (3) @(posedge clk);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
